// File: rtl/gcd_pkg.sv
// Shared types and defaults for the streaming GCD engine.
// Optional step counter output is enabled with the GCD_STEP_COUNT_EN macro.
package gcd_pkg;

  localparam int GCD_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_sub_step.sv
// One subtraction step of the GCD iteration.
// The larger operand loses the smaller one. On a tie, y is reduced, so the next step sees y==0.
module gcd_sub_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] nextX,
  output logic [WIDTH-1:0] nextY,
  output logic             isZero
);

  logic w_x_gt_y;

  assign w_x_gt_y = (x > y);
  assign nextX    = w_x_gt_y ? (x - y) : x;
  assign nextY    = w_x_gt_y ? y : (y - x);
  assign isZero   = (x == '0) || (y == '0);

endmodule

// File: rtl/gcd_stream.sv
// Handshaked GCD engine that uses iterative subtraction and takes one step per cycle.
// Only one operand pair is in flight at a time.
// The optional steps output is present when GCD_STEP_COUNT_EN is defined.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result
`ifdef GCD_STEP_COUNT_EN
  ,
  output logic [WIDTH-1:0] steps
`endif
);

  gcd_state_t       r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_next_x;
  logic [WIDTH-1:0] w_next_y;
  logic             w_is_zero;

  gcd_sub_step #(.WIDTH(WIDTH)) u_step (
    .x      (r_x),
    .y      (r_y),
    .nextX  (w_next_x),
    .nextY  (w_next_y),
    .isZero (w_is_zero)
  );

  assign inReady  = (r_state == IDLE);
  assign outValid = r_out_valid;
  assign result   = r_result;

  // FSM and datapath. The accept, iterate and present phases are driven by r_state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inValid) begin
            r_x     <= a;
            r_y     <= b;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // A zero operand ends the iteration. The other operand, or zero, is the answer.
          if (w_is_zero) begin
            r_result    <= r_x | r_y;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_x <= w_next_x;
            r_y <= w_next_y;
          end
        end
        DONE: begin
          if (outReady) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef GCD_STEP_COUNT_EN
  logic [WIDTH-1:0] r_steps;

  // Count subtraction steps: clear on accept, bump on every non-terminal BUSY edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_steps <= '0;
    end else if (r_state == IDLE && inValid) begin
      r_steps <= '0;
    end else if (r_state == BUSY && !w_is_zero) begin
      r_steps <= r_steps + WIDTH'(1);
    end
  end

  assign steps = r_steps;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and random checks of gcd_stream.
// The bench uses three instances, with WIDTH values of 16, 4 and 8.
// Step counts are checked when GCD_STEP_COUNT_EN is defined.
module tb_gcd_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=16 instance
  logic        in_v16, in_r16, out_v16, out_r16;
  logic [15:0] a16, b16, res16;
  // WIDTH=4 instance
  logic        in_v4, in_r4, out_v4, out_r4;
  logic [3:0]  a4, b4, res4;
  // WIDTH=8 instance
  logic        in_v8, in_r8, out_v8, out_r8;
  logic [7:0]  a8, b8, res8;
`ifdef GCD_STEP_COUNT_EN
  logic [15:0] st16;
  logic [3:0]  st4;
  logic [7:0]  st8;
`endif

  gcd_stream #(.WIDTH(16)) dut16 (
    .clock(clk), .resetN(rst_n), .inValid(in_v16), .inReady(in_r16),
    .a(a16), .b(b16), .outValid(out_v16), .outReady(out_r16), .result(res16)
`ifdef GCD_STEP_COUNT_EN
    , .steps(st16)
`endif
  );

  gcd_stream #(.WIDTH(4)) dut4 (
    .clock(clk), .resetN(rst_n), .inValid(in_v4), .inReady(in_r4),
    .a(a4), .b(b4), .outValid(out_v4), .outReady(out_r4), .result(res4)
`ifdef GCD_STEP_COUNT_EN
    , .steps(st4)
`endif
  );

  gcd_stream #(.WIDTH(8)) dut8 (
    .clock(clk), .resetN(rst_n), .inValid(in_v8), .inReady(in_r8),
    .a(a8), .b(b8), .outValid(out_v8), .outReady(out_r8), .result(res8)
`ifdef GCD_STEP_COUNT_EN
    , .steps(st8)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    int          lat;
    int          s;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Full transaction on the 16-bit instance: accept, count latency, check, consume.
  task automatic tx16(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                      input logic [15:0] xr, input int lat, input int s);
    int n;
    in_v16 = 1'b1; a16 = xa; b16 = xb;
    chk({nm, "_inReady"}, 32'(in_r16), 1);
    step();
    in_v16 = 1'b0;
    n = 0;
    do begin step(); n++; end while (!out_v16 && n < 2000);
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_result"}, 32'(res16), 32'(xr));
`ifdef GCD_STEP_COUNT_EN
    chk({nm, "_steps"}, 32'(st16), s);
`else
    if (s < 0) $display("negative step count in vector %s", nm);
`endif
    out_r16 = 1'b1;
    step();
    out_r16 = 1'b0;
    chk({nm, "_outValid_clear"}, 32'(out_v16), 0);
    chk({nm, "_idle_inReady"}, 32'(in_r16), 1);
  endtask

  task automatic tx4(input string nm, input logic [3:0] xa, input logic [3:0] xb,
                     input logic [3:0] xr, input int lat, input int s);
    int n;
    in_v4 = 1'b1; a4 = xa; b4 = xb;
    step();
    in_v4 = 1'b0;
    n = 0;
    do begin step(); n++; end while (!out_v4 && n < 200);
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_result"}, 32'(res4), 32'(xr));
`ifdef GCD_STEP_COUNT_EN
    chk({nm, "_steps"}, 32'(st4), s);
`else
    if (s < 0) $display("negative step count in vector %s", nm);
`endif
    out_r4 = 1'b1;
    step();
    out_r4 = 1'b0;
    chk({nm, "_outValid_clear"}, 32'(out_v4), 0);
  endtask

  int          n_wait;
  int          got;
  int          c_cyc;
  logic [7:0]  ra, rb;
  logic [7:0]  exp_q[$];

  initial begin
    vecs[0] = '{16'd12,    16'd8,     16'd4,     4, 3};
    vecs[1] = '{16'd0,     16'd0,     16'd0,     1, 0};
    vecs[2] = '{16'd0,     16'd9,     16'd9,     1, 0};
    vecs[3] = '{16'd9,     16'd0,     16'd9,     1, 0};
    vecs[4] = '{16'd7,     16'd7,     16'd7,     2, 1};
    vecs[5] = '{16'd48,    16'd18,    16'd6,     6, 5};
    vecs[6] = '{16'd1,     16'd5,     16'd1,     6, 5};
    vecs[7] = '{16'd21,    16'd6,     16'd3,     6, 5};
    vecs[8] = '{16'd65535, 16'd65535, 16'd65535, 2, 1};

    in_v16 = 0; a16 = 0; b16 = 0; out_r16 = 0;
    in_v4 = 0;  a4 = 0;  b4 = 0;  out_r4 = 0;
    in_v8 = 0;  a8 = 0;  b8 = 0;  out_r8 = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_outValid16", 32'(out_v16), 0);
    chk("reset_inReady16", 32'(in_r16), 1);
    chk("reset_result16", 32'(res16), 0);
    chk("reset_outValid4", 32'(out_v4), 0);
    chk("reset_outValid8", 32'(out_v8), 0);
`ifdef GCD_STEP_COUNT_EN
    chk("reset_steps16", 32'(st16), 0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 9; i++)
      tx16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, vecs[i].s);

    // Reset in the middle of a long computation
    in_v16 = 1'b1; a16 = 16'd200; b16 = 16'd3;
    step();
    in_v16 = 1'b0;
    chk("midrst_busy_inReady", 32'(in_r16), 0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outValid", 32'(out_v16), 0);
    chk("midrst_inReady", 32'(in_r16), 1);
    step();
    chk("midrst_outValid_held", 32'(out_v16), 0);
    chk("midrst_result_cleared", 32'(res16), 0);
    rst_n = 1'b1;
    step();
    tx16("post_rst", 16'd12, 16'd8, 16'd4, 4, 3);

    // Backpressure: result held, new inputs ignored while DONE
    in_v16 = 1'b1; a16 = 16'd12; b16 = 16'd8;
    step();
    a16 = 16'd99; b16 = 16'd3;
    n_wait = 0;
    while (!out_v16 && n_wait < 100) begin step(); n_wait++; end
    chk("bp_outValid", 32'(out_v16), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_result", 32'(res16), 4);
      chk("bp_hold_inReady", 32'(in_r16), 0);
      chk("bp_hold_outValid", 32'(out_v16), 1);
    end
    out_r16 = 1'b1;
    step();
    out_r16 = 1'b0;
    chk("bp_release_idle", 32'(in_r16), 1);
    chk("bp_release_outValid", 32'(out_v16), 0);
    step();
    chk("bp_next_accepted", 32'(in_r16), 0);
    in_v16 = 1'b0;
    n_wait = 0;
    while (!out_v16 && n_wait < 100) begin step(); n_wait++; end
    chk("bp_next_result", 32'(res16), 3);
    out_r16 = 1'b1;
    step();
    out_r16 = 1'b0;

    // Narrow width corner cases
    tx4("w4_15_1", 4'd15, 4'd1, 4'd1, 16, 15);
    tx4("w4_15_15", 4'd15, 4'd15, 4'd15, 2, 1);
    tx4("w4_15_10", 4'd15, 4'd10, 4'd5, 4, 3);

    // Random stream with stalls on both sides
    got = 0;
    c_cyc = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(0, 3) == 0) step();
          ra = 8'($urandom);
          rb = 8'($urandom);
          if ($urandom_range(0, 15) == 0) ra = 8'd0;
          if ($urandom_range(0, 15) == 0) rb = 8'd0;
          in_v8 = 1'b1; a8 = ra; b8 = rb;
          n_wait = 0;
          while (!in_r8 && n_wait < 2000) begin step(); n_wait++; end
          if (!in_r8) begin
            checks++;
            errors++;
            $display("FAIL rand_accept_timeout actual=%0d expected=%0d", n_wait, 2000);
            in_v8 = 1'b0;
            break;
          end
          exp_q.push_back(8'(ref_gcd(int'(ra), int'(rb))));
          step();
          in_v8 = 1'b0;
        end
      end
      begin
        while (got < 1000 && c_cyc < 60000) begin
          out_r8 = ($urandom_range(0, 3) != 0);
          if (out_v8 && out_r8) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rand_extra_result actual=%0d expected=%0d", res8, 0);
            end else begin
              chk("rand_result", 32'(res8), 32'(exp_q.pop_front()));
            end
            got++;
          end
          step();
          c_cyc++;
        end
        out_r8 = 1'b0;
      end
    join
    chk("rand_count", got, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
